// File: rtl/rx_interface_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding, the
// default oversampling ratio and the sample-tick divider computation.
// Used by rx_interface and intended for the matching transmit side.
package rx_interface_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned OversampleDefault = 16;

    // Clock cycles per sample tick; never less than one.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned div;
        div = clk_hz / (baud * oversample);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Sample-tick generator: pulses tick once every DIV clock cycles.
// Ports:
//   CLK     system clock (rising edge)
//   RESET   synchronous active-low reset
//   restart clears the divider so the next tick lands DIV cycles later
//   tick    one-cycle sample strobe
module baud_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == Last)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // No tick in the restart cycle so the first one is a full period later.
    assign tick = !restart && (cnt_q == Last);

endmodule

// File: rtl/rx_interface.sv
// 8N1 serial receiver that pairs bytes into 16-bit words.
// The first accepted byte forms [7:0], the second [15:8]; a completed word
// is held in DATA_OUT until the consumer pops it with RD.
// Ports:
//   CLK       system clock (rising edge)
//   RESET     synchronous active-low reset
//   RX        asynchronous serial input, idle high, LSB first
//   RD        consumer acknowledge, pops the held word
//   DATA_OUT  last assembled word
//   VALID     DATA_OUT holds an unread word
//   FRAME_ERR one-cycle pulse on a bad stop bit
//   OVERRUN   sticky: a completed word was dropped
module rx_interface
    import rx_interface_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = OversampleDefault
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RX,
    input  logic        RD,
    output logic [15:0] DATA_OUT,
    output logic        VALID,
    output logic        FRAME_ERR,
    output logic        OVERRUN
);

    localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CntW-1:0] HalfTick = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    uart_state_e     state_q;
    logic [CntW-1:0] sample_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      low_byte_q;
    logic            phase_q;
    logic            restart;
    logic            tick;
    logic            pop;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign restart = (state_q == StIdle) && !rx_sync_q;
    assign pop     = RD && VALID;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            low_byte_q   <= '0;
            phase_q      <= 1'b0;
            DATA_OUT     <= '0;
            VALID        <= 1'b0;
            FRAME_ERR    <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;

            // Consumer pop; a word load or overrun below overrides this.
            if (pop) begin
                VALID   <= 1'b0;
                OVERRUN <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_q      <= StStart;
                        sample_cnt_q <= '0;
                    end
                end

                StStart: begin
                    if (tick) begin
                        if (sample_cnt_q == HalfTick) begin
                            sample_cnt_q <= '0;
                            bit_cnt_q    <= '0;
                            // Line back high at mid start bit: treat as a glitch.
                            state_q      <= rx_sync_q ? StIdle : StData;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + CntW'(1);
                        end
                    end
                end

                StData: begin
                    if (tick) begin
                        if (sample_cnt_q == LastTick) begin
                            sample_cnt_q <= '0;
                            shift_q      <= {rx_sync_q, shift_q[7:1]};
                            bit_cnt_q    <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StStop;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + CntW'(1);
                        end
                    end
                end

                StStop: begin
                    if (tick) begin
                        if (sample_cnt_q == LastTick) begin
                            sample_cnt_q <= '0;
                            state_q      <= StIdle;
                            if (!rx_sync_q) begin
                                FRAME_ERR <= 1'b1;
                                phase_q   <= 1'b0;
                            end else if (!phase_q) begin
                                low_byte_q <= shift_q;
                                phase_q    <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (!VALID || RD) begin
                                    DATA_OUT <= {shift_q, low_byte_q};
                                    VALID    <= 1'b1;
                                end else begin
                                    OVERRUN <= 1'b1;
                                end
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + CntW'(1);
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_interface.sv
// Randomised bench for rx_interface with a byte/word-level reference model
// and a scoreboard of expected word loads checked by an independent monitor.
module tb_rx_interface;

    localparam int unsigned Os = 16;
    // Start-bit drive to VALID: 2 sync flops, 1 detect, half a bit, 9 bits.
    localparam int unsigned Lat = 2 + 1 + Os / 2 + 9 * Os;
    // Stop-bit cycle index whose RD covers the word-load edge.
    localparam int unsigned RdSlot = Lat - 9 * Os - 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        RX = 1'b1;
    logic        RD = 1'b0;
    logic [15:0] DATA_OUT;
    logic        VALID;
    logic        FRAME_ERR;
    logic        OVERRUN;

    rx_interface #(
        .CLK_HZ    (1_600_000),
        .BAUD      (100_000),
        .OVERSAMPLE(Os)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RX       (RX),
        .RD       (RD),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard and monitor state
    logic [15:0] exp_q[$];
    logic [15:0] mon_w;
    logic        prev_valid = 1'b0;
    logic        prev_fe = 1'b0;
    logic        prev_rst = 1'b0;
    logic [15:0] prev_data = 16'h0;
    int          fe_cnt = 0;
    int          valid_falls = 0;
    int unsigned load_cyc = 0;
    int unsigned start_cyc = 0;

    // Reference model: byte pairing and holding-register behaviour
    bit          m_phase = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_ovr = 1'b0;
    logic [7:0]  m_low = 8'h0;
    logic [15:0] m_data = 16'h0;
    int          exp_fe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " valid"}, 32'(VALID), 32'(m_valid));
        check({tag, " overrun"}, 32'(OVERRUN), 32'(m_ovr));
        check({tag, " data_out"}, 32'(DATA_OUT), 32'(m_data));
        check({tag, " frame_err count"}, 32'(fe_cnt), 32'(exp_fe));
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop, input bit rd);
        bit rd_eff;
        bit complete;
        rd_eff   = rd && m_valid;
        complete = 1'b0;
        if (rd_eff) m_ovr = 1'b0;
        if (!stop) begin
            exp_fe++;
            m_phase = 1'b0;
        end else if (!m_phase) begin
            m_low   = b;
            m_phase = 1'b1;
        end else begin
            m_phase  = 1'b0;
            complete = 1'b1;
            if (m_valid && !rd) begin
                m_ovr = 1'b1;
            end else begin
                m_data  = {b, m_low};
                m_valid = 1'b1;
                exp_q.push_back(m_data);
            end
        end
        if (rd_eff && !complete) m_valid = 1'b0;
    endtask

    // Called on a negedge; returns on a negedge after an idle gap.
    task automatic send(input logic [7:0] b, input bit stop, input bit rd);
        model_byte(b, stop, rd);
        start_cyc = cyc;
        RX = 1'b0;
        repeat (Os) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (Os) @(negedge CLK);
        end
        RX = stop;
        for (int c = 0; c < Os; c++) begin
            RD = rd && (c == RdSlot);
            @(negedge CLK);
        end
        RD = 1'b0;
        RX = 1'b1;
        repeat (20) @(negedge CLK);
    endtask

    task automatic pulse_rd();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        RD = 1'b1;
        @(negedge CLK);
        RD = 1'b0;
        check_state("after rd");
    endtask

    // Monitor: every word load must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET && prev_rst) begin
                if (VALID && (!prev_valid || DATA_OUT !== prev_data)) begin
                    n_tests++;
                    load_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL load: got word %h, required no load", DATA_OUT);
                    end else begin
                        mon_w = exp_q.pop_front();
                        if (DATA_OUT !== mon_w) begin
                            n_fail++;
                            $display("FAIL load: got word %h, required %h", DATA_OUT, mon_w);
                        end
                    end
                end
                if (DATA_OUT !== prev_data) begin
                    n_tests++;
                    if (!VALID) begin
                        n_fail++;
                        $display("FAIL data_out stable: got change %h->%h, required no change",
                                 prev_data, DATA_OUT);
                    end
                end
                if (!VALID && prev_valid) valid_falls++;
                if (FRAME_ERR) begin
                    fe_cnt++;
                    n_tests++;
                    if (prev_fe) begin
                        n_fail++;
                        $display("FAIL frame_err width: got 2+ cycles, required 1");
                    end
                end
            end
            prev_valid = VALID;
            prev_fe    = FRAME_ERR;
            prev_data  = DATA_OUT;
            prev_rst   = RESET;
        end
    end

    initial begin
        int          falls;
        logic [7:0]  b;
        bit          stop;
        bit          rd;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset data_out", 32'(DATA_OUT), 32'h0);
        check("reset valid", 32'(VALID), 32'h0);
        check("reset frame_err", 32'(FRAME_ERR), 32'h0);
        check("reset overrun", 32'(OVERRUN), 32'h0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        // Basic word with latency
        send(8'h34, 1'b1, 1'b0);
        send(8'h12, 1'b1, 1'b0);
        check("load latency", load_cyc - start_cyc, Lat);
        check_state("word 1234");

        // Overrun while unread
        send(8'hEF, 1'b1, 1'b0);
        send(8'hBE, 1'b1, 1'b0);
        check_state("overrun");
        pulse_rd();

        // Short glitch must not start a frame
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        RX = 1'b1;
        repeat (60) @(negedge CLK);
        check_state("glitch");

        // Framing error resets the byte pairing
        send(8'hAA, 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        check_state("frame error");
        pulse_rd();

        // RD coincident with a word load keeps VALID high
        send(8'h3C, 1'b1, 1'b0);
        send(8'h5A, 1'b1, 1'b0);
        falls = valid_falls;
        send(8'hC3, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        check("valid continuous", 32'(valid_falls), 32'(falls));
        check_state("rd at load");

        // Reset during bit 4 of a second byte
        send(8'h77, 1'b1, 1'b0);
        RX = 1'b0;
        repeat (Os) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            RX = (i % 2 == 0);
            repeat (Os) @(negedge CLK);
        end
        RX    = 1'b1;
        RESET = 1'b0;
        m_phase = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 16'h0;
        repeat (3) @(negedge CLK);
        check_state("in reset");
        RESET = 1'b1;
        repeat (10) @(negedge CLK);
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        check_state("after reset");
        pulse_rd();

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(7) != 0);
            rd   = ($urandom_range(3) == 0);
            if ($urandom_range(3) == 0) pulse_rd();
            // A load with VALID held high is only visible if the word differs.
            if (m_phase && stop && m_valid && rd && ({b, m_low} == m_data)) b = b ^ 8'h01;
            send(b, stop, rd);
            check_state("random");
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_interface.md
RX_INTERFACE -- requirements
Module: rx_interface

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit.
REQ-004 SHALL have port CLK  input  1  system clock; the block uses this one clock only, all logic on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port RX  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-007 SHALL have port RD  input  1  consumer acknowledge; pops the held word.
REQ-008 SHALL have port DATA_OUT  output  16  last assembled word.
REQ-009 SHALL have port VALID  output  1  DATA_OUT holds an unread word.
REQ-010 SHALL have port FRAME_ERR  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port OVERRUN  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL generate a sample tick every DIV = CLK_HZ/(BAUD*OVERSAMPLE) cycles (integer division, minimum 1); the tick counter free-runs in IDLE and restarts at 0 on start-bit detection.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized RX = 0.
REQ-016 START: at tick OVERSAMPLE/2-1, RX = 0 ->DATA; RX = 1 ->IDLE (glitch, no output).
REQ-017 DATA: sample one bit every OVERSAMPLE ticks into a shift register, LSB first; after bit 7 ->STOP.
REQ-018 STOP: after OVERSAMPLE ticks sample RX. RX = 1 accepts the byte. RX = 0 pulses FRAME_ERR for 1 cycle, discards the byte, and resets the byte-pair phase to low. Either way ->IDLE.
REQ-019 Byte assembly SHALL place the first accepted byte in [7:0] and the second in [15:8]; the phase toggles on each accepted byte.
REQ-020 On the second byte's stop sample, if VALID = 0 or RD = 1, SHALL load the word into DATA_OUT and set VALID on the next edge; latency = 1 cycle after the stop sample.
REQ-021 RD with VALID = 1 and no word completing SHALL clear VALID on the next edge.
REQ-022 RD with VALID = 0 SHALL be ignored.
REQ-023 A word completing while VALID = 1 and RD = 0 SHALL be dropped, leave DATA_OUT unchanged, and set OVERRUN.
REQ-024 OVERRUN SHALL clear on the edge after an RD with VALID = 1, unless a new overrun occurs in the same cycle (set wins).
REQ-025 DATA_OUT SHALL change only on a word load.

Reset
REQ-026 RESET = 0 at a clock edge SHALL force FSM = IDLE, tick counter = 0, shift register = 0, phase = low, DATA_OUT = 16'h0000, VALID = 0, FRAME_ERR = 0, OVERRUN = 0, and synchronizer flops = 1.
REQ-027 Reset mid-frame SHALL discard the partial byte and any held low byte; the next falling RX edge after release starts a fresh frame.

Structure
REQ-028 A shared package/header SHALL hold the FSM state encodings, the OVERSAMPLE default and the DIV computation; the TX-side interface SHALL reuse the same package.
REQ-029 Tick generation SHALL live in sub-module baud_tick_gen (CLK, RESET, restart, tick), instantiated once.
REQ-030 The word assembler/holding register SHALL stay inline in rx_interface.

Verification (CLK_HZ=1_600_000, BAUD=100_000 -> DIV=1, 16 cycles/bit)
REQ-031 Bench SHALL cover: bytes 0x34 then 0x12 sent, RD = 0 -> VALID rises 1 cycle after the second stop sample, DATA_OUT = 16'h1234.
REQ-032 Bench SHALL cover: RX low for 4 cycles only -> no sampling, FSM back to IDLE, VALID and FRAME_ERR stay 0.
REQ-033 Bench SHALL cover: byte 0xAA with stop bit = 0, then 0x55, 0x66 -> one FRAME_ERR pulse, DATA_OUT = 16'h6655.
REQ-034 Bench SHALL cover: word 16'h1234 unread, then 16'hBEEF received -> OVERRUN = 1, DATA_OUT stays 16'h1234; RD -> VALID = 0 and OVERRUN = 0 next cycle.
REQ-035 Bench SHALL cover: RD held high on the cycle a second word completes -> DATA_OUT updates and VALID stays 1 continuously.
REQ-036 Bench SHALL cover: RESET = 0 during bit 4 of the second byte, then 0x01, 0x02 -> all outputs 0 during reset, then DATA_OUT = 16'h0201.
